// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One access at a time: IDLE picks a winner, ISSUE drives the memory command
// for one cycle, and reads spend one extra cycle in RD_WAIT to capture data.
//
// Handshake: a requester raises reqN_valid with stable we/addr/wdata and keeps
// it high until it sees reqN_gnt. The gnt pulse marks the cycle its command is
// on the memory port. For reads, reqN_rvalid pulses two cycles after gnt with
// reqN_rdata, which then holds until that requester's next read completes.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_gnt,
  output logic        req0_rvalid,
  output logic [7:0]  req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_gnt,
  output logic        req1_rvalid,
  output logic [7:0]  req1_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RD_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;     // requester granted most recently
  logic        r_win;      // requester owning the access in flight
  logic        r_we;       // access in flight is a write
  logic        w_accept;
  logic        w_win;
  logic        w_sel_we;
  logic [15:0] w_sel_addr;
  logic [7:0]  w_sel_wdata;

  assign dbg_state = r_state;

  // Winner selection and next-state decode
  always_comb begin
    w_win       = 1'b0;
    w_accept    = 1'b0;
    w_next      = r_state;
    if (req0_valid && req1_valid) begin
      w_win = ~r_last;
    end else if (req1_valid) begin
      w_win = 1'b1;
    end
    w_sel_we    = w_win ? req1_we    : req0_we;
    w_sel_addr  = w_win ? req1_addr  : req0_addr;
    w_sel_wdata = w_win ? req1_wdata : req0_wdata;
    case (r_state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE:   w_next = r_we ? S_IDLE : S_RD_WAIT;
      S_RD_WAIT: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Registered memory command, grant/rvalid pulses, read data and pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last      <= 1'b1;
      r_win       <= 1'b0;
      r_we        <= 1'b0;
      req0_gnt    <= 1'b0;
      req1_gnt    <= 1'b0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata  <= 8'h00;
      req1_rdata  <= 8'h00;
      mem_addr    <= 16'h0000;
      mem_wdata   <= 8'h00;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      req0_gnt    <= 1'b0;
      req1_gnt    <= 1'b0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      busy        <= (w_next != S_IDLE);
      if (w_accept) begin
        r_win     <= w_win;
        r_we      <= w_sel_we;
        r_last    <= w_win;
        mem_addr  <= w_sel_addr;
        mem_wdata <= w_sel_wdata;
        mem_we    <= w_sel_we;
        mem_re    <= ~w_sel_we;
        req0_gnt  <= ~w_win;
        req1_gnt  <= w_win;
      end
      if (r_state == S_RD_WAIT) begin
        if (r_win) begin
          req1_rdata  <= mem_rdata;
          req1_rvalid <= 1'b1;
        end else begin
          req0_rdata  <= mem_rdata;
          req0_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-requester traffic,
// checked by a transaction-level reference model and a scoreboard monitor.
module tb_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        v    [2];
  logic        we_s [2];
  logic [15:0] ad_s [2];
  logic [7:0]  wd_s [2];
  logic        req0_gnt, req1_gnt, req0_rvalid, req1_rvalid;
  logic [7:0]  req0_rdata, req1_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re, busy;
  logic [7:0]  mem_rdata = 8'h00;
  logic [1:0]  dbg_state;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req0_we(we_s[0]), .req0_addr(ad_s[0]), .req0_wdata(wd_s[0]),
    .req0_gnt(req0_gnt), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(v[1]), .req1_we(we_s[1]), .req1_addr(ad_s[1]), .req1_wdata(wd_s[1]),
    .req1_gnt(req1_gnt), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- counters ----------------
  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic note_fail(input string name);
    n_total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h20) ? 8'hC3 : 8'(a * 8'd7 + 8'd3);
  endfunction

  // ---------------- memory responder (256 locations, aliased by addr[7:0]) ----------------
  logic [7:0] tb_mem [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) tb_mem[i] = init_val(8'(i));
    end else begin
      if (mem_we) tb_mem[mem_addr[7:0]] = mem_wdata;
      if (mem_re) mem_rdata <= tb_mem[mem_addr[7:0]];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          cyc;
    int          id;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } gexp_t;
  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rexp_t;

  gexp_t      gq[$];
  rexp_t      rq0[$];
  rexp_t      rq1[$];
  logic [7:0] shadow [256];
  logic [7:0] hold [2];
  int         m_free = 0;   // first cycle the memory port is free again
  int         m_last = 1;
  int         m_win;
  int         m_t;
  gexp_t      m_g;
  rexp_t      m_rd;

  // One decision per clock: the port is free from m_free on; a waiting
  // requester is taken, alternating when both wait.
  always @(posedge clk) begin
    cyc = cyc + 1;
    m_t = cyc - 1;
    if (reset) begin
      gq.delete(); rq0.delete(); rq1.delete();
      for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));
      hold[0] = 8'h00; hold[1] = 8'h00;
      m_free = cyc;
      m_last = 1;
    end else if (m_t >= m_free && (v[0] || v[1])) begin
      if (v[0] && v[1]) m_win = 1 - m_last;
      else m_win = v[1] ? 1 : 0;
      m_last     = m_win;
      m_g.cyc    = cyc;
      m_g.id     = m_win;
      m_g.we     = we_s[m_win];
      m_g.addr   = ad_s[m_win];
      m_g.wdata  = wd_s[m_win];
      gq.push_back(m_g);
      if (m_g.we) begin
        shadow[m_g.addr[7:0]] = m_g.wdata;
        m_free = m_t + 2;
      end else begin
        m_rd.cyc  = cyc + 2;
        m_rd.data = shadow[m_g.addr[7:0]];
        if (m_win == 1) rq1.push_back(m_rd);
        else rq0.push_back(m_rd);
        m_free = m_t + 3;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int    glog[$];
  gexp_t s_g;
  rexp_t s_r;

  always @(negedge clk) begin
    chk("gnt_exclusive", {31'b0, req0_gnt & req1_gnt}, 0);
    chk("we_re_exclusive", {31'b0, mem_we & mem_re}, 0);
    chk("busy", {31'b0, busy}, {31'b0, (cyc < m_free)});

    while (gq.size() > 0 && gq[0].cyc < cyc) begin
      note_fail("missed_gnt");
      void'(gq.pop_front());
    end
    if (req0_gnt || req1_gnt) begin
      glog.push_back(req1_gnt ? 1 : 0);
      if (gq.size() == 0) begin
        note_fail("unexpected_gnt");
      end else begin
        s_g = gq.pop_front();
        chk("gnt_cycle", cyc, s_g.cyc);
        chk("gnt_id", {31'b0, req1_gnt}, s_g.id);
        chk("mem_we", {31'b0, mem_we}, {31'b0, s_g.we});
        chk("mem_re", {31'b0, mem_re}, {31'b0, ~s_g.we});
        chk("mem_addr", {16'b0, mem_addr}, {16'b0, s_g.addr});
        if (s_g.we) chk("mem_wdata", {24'b0, mem_wdata}, {24'b0, s_g.wdata});
      end
    end else begin
      chk("idle_cmd", {30'b0, mem_we, mem_re}, 0);
    end

    while (rq0.size() > 0 && rq0[0].cyc < cyc) begin
      note_fail("missed_rvalid0");
      void'(rq0.pop_front());
    end
    if (req0_rvalid) begin
      if (rq0.size() == 0) note_fail("unexpected_rvalid0");
      else begin
        s_r = rq0.pop_front();
        chk("rvalid0_cycle", cyc, s_r.cyc);
        chk("rvalid0_data", {24'b0, req0_rdata}, {24'b0, s_r.data});
        hold[0] = s_r.data;
      end
    end
    while (rq1.size() > 0 && rq1[0].cyc < cyc) begin
      note_fail("missed_rvalid1");
      void'(rq1.pop_front());
    end
    if (req1_rvalid) begin
      if (rq1.size() == 0) note_fail("unexpected_rvalid1");
      else begin
        s_r = rq1.pop_front();
        chk("rvalid1_cycle", cyc, s_r.cyc);
        chk("rvalid1_data", {24'b0, req1_rdata}, {24'b0, s_r.data});
        hold[1] = s_r.data;
      end
    end
    chk("rdata0_hold", {24'b0, req0_rdata}, {24'b0, hold[0]});
    chk("rdata1_hold", {24'b0, req1_rdata}, {24'b0, hold[1]});
  end

  // ---------------- driver tasks ----------------
  // Raise a request at a falling edge and hold it until the grant is seen.
  task automatic do_req(input int id, input logic we, input logic [15:0] a, input logic [7:0] d);
    int n;
    v[id] = 1'b1; we_s[id] = we; ad_s[id] = a; wd_s[id] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(id == 0 ? req0_gnt : req1_gnt) && n < 40);
    if (!(id == 0 ? req0_gnt : req1_gnt)) note_fail("gnt_timeout");
    v[id] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_traffic(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_req(id, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
    end
  endtask

  task automatic check_glog(input string name, input int n);
    chk({name, "_count"}, glog.size(), n);
    for (int i = 0; i < n && i < glog.size(); i++) chk(name, glog[i], i % 2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; we_s[i] = 1'b0; ad_s[i] = 16'h0; wd_s[i] = 8'h0;
    end
    @(negedge clk);
    do_reset(3);

    // Reset values
    chk("rst_gnt", {30'b0, req0_gnt, req1_gnt}, 0);
    chk("rst_rvalid", {30'b0, req0_rvalid, req1_rvalid}, 0);
    chk("rst_mem_cmd", {30'b0, mem_we, mem_re}, 0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 0);
    chk("rst_mem_wdata", {24'b0, mem_wdata}, 0);
    chk("rst_rdata", {16'b0, req0_rdata, req1_rdata}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_state", {30'b0, dbg_state}, 0);

    // Single write, single read, then a read by requester 0 to load its rdata
    do_req(0, 1'b1, 16'h0010, 8'h5A);
    repeat (2) @(negedge clk);
    do_req(1, 1'b0, 16'h0020, 8'h00);
    repeat (3) @(negedge clk);
    chk("read_c3", {24'b0, req1_rdata}, 32'hC3);
    do_req(0, 1'b0, 16'h0010, 8'h00);
    repeat (3) @(negedge clk);
    chk("read_back_5a", {24'b0, req0_rdata}, 32'h5A);

    // Reset while the read sits in RD_WAIT: no rvalid, rdata cleared
    do_req(0, 1'b0, 16'h0040, 8'h00);
    @(negedge clk);
    do_reset(1);
    chk("abort_rdata0", {24'b0, req0_rdata}, 0);
    chk("abort_mem_re", {31'b0, mem_re}, 0);
    repeat (3) @(negedge clk);

    // Ties after reset: 0, 1, then 0 again
    do_reset(1);
    glog.delete();
    fork
      begin do_req(0, 1'b1, 16'h0100, 8'h11); do_req(0, 1'b1, 16'h0101, 8'h12); end
      begin do_req(1, 1'b1, 16'h0200, 8'h21); do_req(1, 1'b1, 16'h0201, 8'h22); end
    join
    repeat (3) @(negedge clk);
    check_glog("tie_order", 4);

    // Fairness: both requesting writes continuously
    do_reset(1);
    glog.delete();
    fork
      for (int i = 0; i < 4; i++) do_req(0, 1'b1, 16'(16'h0300 + i), 8'(i));
      for (int i = 0; i < 4; i++) do_req(1, 1'b1, 16'(16'h0400 + i), 8'(8'h80 + i));
    join
    repeat (3) @(negedge clk);
    check_glog("fair_order", 8);

    // Read completing while requester 1 becomes pending
    fork
      do_req(0, 1'b0, 16'h0300, 8'h00);
      begin repeat (2) @(negedge clk); do_req(1, 1'b1, 16'h0500, 8'h77); end
    join
    repeat (4) @(negedge clk);

    // Random mixed traffic from both requesters
    fork
      rand_traffic(0, 30);
      rand_traffic(1, 30);
    join
    repeat (8) @(negedge clk);

    chk("gnt_queue_drained", gq.size(), 0);
    chk("rd0_queue_drained", rq0.size(), 0);
    chk("rd1_queue_drained", rq1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit
  initial begin
    #300000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Ports: clk  in  1  rising-edge clock.
REQ-002 Ports: reset  in  1  synchronous, active-high reset.
REQ-003 Ports: reqN_valid  in  1  requester N (N=0,1) access request; held high until grant.
REQ-004 Ports: reqN_we  in  1  1=write, 0=read; stable while reqN_valid high.
REQ-005 Ports: reqN_addr  in  16  data address; stable while reqN_valid high.
REQ-006 Ports: reqN_wdata  in  8  write data; stable while reqN_valid high.
REQ-007 Ports: reqN_gnt  out  1  one-cycle pulse marking the cycle requester N's access is on the memory port.
REQ-008 Ports: reqN_rvalid  out  1  one-cycle pulse, read data for requester N valid.
REQ-009 Ports: reqN_rdata  out  8  read data, valid while reqN_rvalid high.
REQ-010 Ports: mem_addr  out  16, mem_wdata  out  8, mem_we  out  1, mem_re  out  1  single-port data memory command.
REQ-011 Ports: mem_rdata  in  8  memory read data, valid the cycle after mem_re.
REQ-012 Ports: busy  out  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, RD_WAIT.
REQ-014 IDLE: if any reqN_valid, SHALL select a winner, register its fields, and move to ISSUE; else stay IDLE.
REQ-015 Arbitration SHALL be round-robin: single request wins outright; with both requesting, the requester not granted last wins.
REQ-016 The last-granted pointer SHALL update only when a grant is issued.
REQ-017 ISSUE: mem_addr and mem_wdata from the registered winner; winner's reqN_gnt=1; mem_we=1 for writes, mem_re=1 for reads; all outputs registered.
REQ-018 ISSUE SHALL last exactly one cycle; requests are not sampled in ISSUE or RD_WAIT.
REQ-019 ISSUE -> IDLE for writes; ISSUE -> RD_WAIT for reads.
REQ-020 RD_WAIT SHALL capture mem_rdata into the winner's reqN_rdata and move to IDLE.
REQ-021 reqN_rvalid SHALL pulse for one cycle in the cycle after RD_WAIT, concurrent with IDLE.
REQ-022 A new request MAY be accepted in that same IDLE cycle.
REQ-023 reqN_rdata SHALL hold its value until the next read completes for that requester.
REQ-024 Latency: write request first seen in IDLE at cycle T -> gnt/mem_we at T+1 -> IDLE at T+2.
REQ-025 Latency: read request first seen in IDLE at cycle T -> gnt/mem_re at T+1 -> RD_WAIT at T+2 -> rvalid at T+3.
REQ-026 At most one of req0_gnt/req1_gnt, and at most one of mem_we/mem_re, SHALL be high in any cycle.
REQ-027 mem_we and mem_re SHALL be 0 outside ISSUE.
REQ-028 A requester dropping reqN_valid before grant SHALL NOT be granted (protocol violation, no recovery required).
REQ-029 Back-to-back requests from one requester SHALL NOT starve the other: with both continuously requesting, grants alternate 0,1,0,1.

Reset
REQ-030 reset SHALL be sampled on clk; when high: state=IDLE; all gnt, rvalid, mem_we, mem_re, busy=0; mem_addr, mem_wdata, reqN_rdata=0.
REQ-031 On reset, the last-granted pointer SHALL be 1, so requester 0 wins the first tie.
REQ-032 Reset in ISSUE or RD_WAIT SHALL abort the access; no rvalid SHALL be produced for the aborted read.
REQ-033 reset SHALL take priority over all other inputs.

Verification
REQ-034 Single write: req0 write addr=0x0010 wdata=0x5A at T -> T+1 mem_we=1, mem_addr=0x0010, mem_wdata=0x5A, req0_gnt=1; T+2 busy=0.
REQ-035 Single read: req1 read addr=0x0020, memory returns 0xC3 -> T+1 mem_re=1, req1_gnt=1; T+3 req1_rvalid=1, req1_rdata=0xC3, req0_rvalid=0.
REQ-036 Tie after reset: both request at T -> requester 0 granted at T+1; requester 1 granted next; third tie goes to requester 0.
REQ-037 Fairness: both request writes continuously for 8 grants -> grant sequence 0,1,0,1,0,1,0,1; exactly one gnt per ISSUE cycle.
REQ-038 Reset mid-read: req0 read, reset asserted in RD_WAIT -> next cycle IDLE, no req0_rvalid, req0_rdata=0, mem_re=0.
REQ-039 Overlap: read completes (rvalid) while req1 is pending in the same cycle -> rvalid pulse and req1 accepted; req1_gnt on the following cycle.
